// File: rtl/fifo_watermark_monitor_if.sv
// Threshold/strobe bundle between the flow-control FSM, the datapath and the watermark monitor.
// master = FSM/datapath side, slave = monitor side.
interface fifo_watermark_monitor_if #(parameter int CNT_W = 5);
  logic               init;
  logic [CNT_W-1:0]   main_fifo_low, main_fifo_high;
  logic [CNT_W-1:0]   Vco_low, Vco_high;
  logic [CNT_W-1:0]   Vc1_low, Vc1_high;
  logic [CNT_W-1:0]   Do_low, Do_high;
  logic [CNT_W-1:0]   D1_low, D1_high;
  logic [4:0]         push;
  logic [4:0]         pop;
  logic               err_clr;
  logic [5*CNT_W-1:0] occ;
  logic [4:0]         empties;
  logic [4:0]         almost_empty;
  logic [4:0]         almost_full;
  logic [4:0]         pause;
  logic [4:0]         errors;
  logic [4:0]         cfg_err;

  modport master (
    output init, main_fifo_low, main_fifo_high, Vco_low, Vco_high, Vc1_low, Vc1_high,
           Do_low, Do_high, D1_low, D1_high, push, pop, err_clr,
    input  occ, empties, almost_empty, almost_full, pause, errors, cfg_err
  );

  modport slave (
    input  init, main_fifo_low, main_fifo_high, Vco_low, Vco_high, Vc1_low, Vc1_high,
           Do_low, Do_high, D1_low, D1_high, push, pop, err_clr,
    output occ, empties, almost_empty, almost_full, pause, errors, cfg_err
  );
endinterface

// File: rtl/fifo_watermark_monitor.sv
// Occupancy/watermark tracker for five FIFOs; flags registered 1 cycle after push/pop, no backpressure of its own.
// WM_HYSTERESIS_EN: pause latches between high and low watermarks instead of mirroring almost_full.
module fifo_watermark_monitor #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  fifo_watermark_monitor_if.slave  bus
);
  localparam int              NF       = 5;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LOW_RST  = CNT_W'(1);
  localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(DEPTH - 1);

  logic [CNT_W-1:0] occ_q   [NF];
  logic [CNT_W-1:0] occ_nxt [NF];
  logic [CNT_W-1:0] low_q   [NF];
  logic [CNT_W-1:0] high_q  [NF];
  logic [CNT_W-1:0] cfg_lo  [NF];
  logic [CNT_W-1:0] cfg_hi  [NF];

  logic [NF-1:0] cfg_ok, err_evt, empty_nxt, ae_nxt, af_nxt, pause_nxt;
  logic [NF-1:0] empty_q, ae_q, af_q, pause_q, err_q, cfg_err_q;

  always_comb begin
    cfg_lo[0] = bus.main_fifo_low;  cfg_hi[0] = bus.main_fifo_high;
    cfg_lo[1] = bus.Vco_low;        cfg_hi[1] = bus.Vco_high;
    cfg_lo[2] = bus.Vc1_low;        cfg_hi[2] = bus.Vc1_high;
    cfg_lo[3] = bus.Do_low;         cfg_hi[3] = bus.Do_high;
    cfg_lo[4] = bus.D1_low;         cfg_hi[4] = bus.D1_high;
    for (int i = 0; i < NF; i++) begin
      occ_nxt[i] = occ_q[i];
      err_evt[i] = 1'b0;
      case ({bus.push[i], bus.pop[i]})
        2'b10: begin
          if (occ_q[i] == DEPTH_C) err_evt[i] = 1'b1;
          else                     occ_nxt[i] = occ_q[i] + CNT_W'(1);
        end
        2'b01: begin
          if (occ_q[i] == '0) err_evt[i] = 1'b1;
          else                occ_nxt[i] = occ_q[i] - CNT_W'(1);
        end
        2'b11: begin
          // Simultaneous pop on an empty FIFO reads nothing, so the push lands.
          if (occ_q[i] == '0) begin
            occ_nxt[i] = CNT_W'(1);
            err_evt[i] = 1'b1;
          end
        end
        default: ;
      endcase
      cfg_ok[i]    = (cfg_lo[i] < cfg_hi[i]) && (cfg_hi[i] <= DEPTH_C);
      empty_nxt[i] = (occ_nxt[i] == '0);
      ae_nxt[i]    = (occ_nxt[i] <= low_q[i]);
      af_nxt[i]    = (occ_nxt[i] >= high_q[i]);
`ifdef WM_HYSTERESIS_EN
      if (af_nxt[i])      pause_nxt[i] = 1'b1;
      else if (ae_nxt[i]) pause_nxt[i] = 1'b0;
      else                pause_nxt[i] = pause_q[i];
`else
      pause_nxt[i] = af_nxt[i];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NF; i++) begin
        occ_q[i]  <= '0;
        low_q[i]  <= LOW_RST;
        high_q[i] <= HIGH_RST;
      end
      empty_q   <= '1;
      ae_q      <= '1;
      af_q      <= '0;
      pause_q   <= '0;
      err_q     <= '0;
      cfg_err_q <= '0;
    end else begin
      for (int i = 0; i < NF; i++) begin
        occ_q[i] <= occ_nxt[i];
        if (bus.init && cfg_ok[i]) begin
          low_q[i]  <= cfg_lo[i];
          high_q[i] <= cfg_hi[i];
        end
      end
      empty_q   <= empty_nxt;
      ae_q      <= ae_nxt;
      af_q      <= af_nxt;
      pause_q   <= pause_nxt;
      err_q     <= (err_q & ~{NF{bus.err_clr}}) | err_evt;
      cfg_err_q <= (cfg_err_q & ~{NF{bus.err_clr}}) | ({NF{bus.init}} & ~cfg_ok);
    end
  end

  for (genvar gi = 0; gi < NF; gi++) begin : g_occ
    assign bus.occ[gi*CNT_W +: CNT_W] = occ_q[gi];
  end

  assign bus.empties      = empty_q;
  assign bus.almost_empty = ae_q;
  assign bus.almost_full  = af_q;
  assign bus.pause        = pause_q;
  assign bus.errors       = err_q;
  assign bus.cfg_err      = cfg_err_q;
endmodule

// File: tb/tb_fifo_watermark_monitor.sv
// Directed bench for fifo_watermark_monitor: stimulus queues expected state, a negedge monitor compares.
module tb_fifo_watermark_monitor;
  logic clk;
  logic reset;

`ifdef WM_HYSTERESIS_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  fifo_watermark_monitor_if #(.CNT_W(5)) bus ();

  fifo_watermark_monitor #(.DEPTH(16), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    int          id;
    logic [24:0] occ;
    logic [4:0]  emp, ae, af, pause, err, cfg;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input int id, input string nm, input logic [24:0] act, input logic [24:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL check %0d %s: got %h expected %h", id, nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      cur = sbq.pop_front();
      chk(cur.id, "occ",          bus.occ,                  cur.occ);
      chk(cur.id, "empties",      {20'd0, bus.empties},      {20'd0, cur.emp});
      chk(cur.id, "almost_empty", {20'd0, bus.almost_empty}, {20'd0, cur.ae});
      chk(cur.id, "almost_full",  {20'd0, bus.almost_full},  {20'd0, cur.af});
      chk(cur.id, "pause",        {20'd0, bus.pause},        {20'd0, cur.pause});
      chk(cur.id, "errors",       {20'd0, bus.errors},       {20'd0, cur.err});
      chk(cur.id, "cfg_err",      {20'd0, bus.cfg_err},      {20'd0, cur.cfg});
    end
  end

  task automatic step(input logic rst, input logic ini, input logic clr,
                      input logic [4:0] p, input logic [4:0] q);
    reset = rst; bus.init = ini; bus.err_clr = clr; bus.push = p; bus.pop = q;
    @(posedge clk);
    #1;
    reset = 1'b0; bus.init = 1'b0; bus.err_clr = 1'b0; bus.push = 5'd0; bus.pop = 5'd0;
  endtask

  task automatic exp_push(input int id, input logic [24:0] o, input logic [4:0] e,
                          input logic [4:0] a, input logic [4:0] f, input logic [4:0] p,
                          input logic [4:0] er, input logic [4:0] c);
    exp_t x;
    x.id = id; x.occ = o; x.emp = e; x.ae = a; x.af = f; x.pause = p; x.err = er; x.cfg = c;
    sbq.push_back(x);
  endtask

  initial begin
    reset = 1'b1;
    bus.init = 1'b0; bus.err_clr = 1'b0; bus.push = 5'd0; bus.pop = 5'd0;
    bus.main_fifo_low = 5'd3;  bus.main_fifo_high = 5'd6;
    bus.Vco_low       = 5'd2;  bus.Vco_high       = 5'd10;
    bus.Vc1_low       = 5'd10; bus.Vc1_high       = 5'd7;
    bus.Do_low        = 5'd1;  bus.Do_high        = 5'd15;
    bus.D1_low        = 5'd4;  bus.D1_high        = 5'd16;

    // Reset and idle
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    exp_push(1, 25'd0, 5'h1F, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h00);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    exp_push(2, 25'd0, 5'h1F, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h00);

    // Threshold load: VC1 has low > high and is rejected
    step(0, 1, 0, 0, 0);
    exp_push(3, 25'd0, 5'h1F, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h04);

    // Fill main to 6 with thresholds 3/6
    for (int k = 1; k <= 6; k++) begin
      step(0, 0, 0, 5'h01, 5'h00);
      if (k >= 3)
        exp_push(10 + k, 25'(k), 5'h1E, (k <= 3) ? 5'h1F : 5'h1E,
                 (k >= 6) ? 5'h01 : 5'h00, (k >= 6) ? 5'h01 : 5'h00, 5'h00, 5'h04);
    end

    // Drain to 3, watching pause hysteresis
    step(0, 0, 0, 5'h00, 5'h01);
    exp_push(20, 25'd5, 5'h1E, 5'h1E, 5'h00, HYST ? 5'h01 : 5'h00, 5'h00, 5'h04);
    step(0, 0, 0, 5'h00, 5'h01);
    exp_push(21, 25'd4, 5'h1E, 5'h1E, 5'h00, HYST ? 5'h01 : 5'h00, 5'h00, 5'h04);
    step(0, 0, 0, 5'h00, 5'h01);
    exp_push(22, 25'd3, 5'h1E, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h04);
    step(0, 0, 0, 5'h01, 5'h00);
    exp_push(23, 25'd4, 5'h1E, 5'h1E, 5'h00, 5'h00, 5'h00, 5'h04);
    step(0, 0, 0, 5'h01, 5'h00);
    exp_push(24, 25'd5, 5'h1E, 5'h1E, 5'h00, 5'h00, 5'h00, 5'h04);

    // Simultaneous push+pop at occ 5 holds everything
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 5'h01, 5'h01);
      exp_push(30 + k, 25'd5, 5'h1E, 5'h1E, 5'h00, 5'h00, 5'h00, 5'h04);
    end

    // D1 overflow: 17 pushes into a 16-deep FIFO (high watermark 16)
    for (int k = 1; k <= 17; k++) begin
      step(0, 0, 0, 5'h10, 5'h00);
      if (k == 16) exp_push(40, 25'h1000005, 5'h0E, 5'h0E, 5'h10, 5'h10, 5'h00, 5'h04);
      if (k == 17) exp_push(41, 25'h1000005, 5'h0E, 5'h0E, 5'h10, 5'h10, 5'h10, 5'h04);
    end
    step(0, 0, 1, 5'h00, 5'h00);
    exp_push(42, 25'h1000005, 5'h0E, 5'h0E, 5'h10, 5'h10, 5'h00, 5'h00);
    step(0, 0, 1, 5'h10, 5'h00);
    exp_push(43, 25'h1000005, 5'h0E, 5'h0E, 5'h10, 5'h10, 5'h10, 5'h00);

    // Underflow cases
    step(0, 0, 0, 5'h00, 5'h02);
    exp_push(44, 25'h1000005, 5'h0E, 5'h0E, 5'h10, 5'h10, 5'h12, 5'h00);
    step(0, 0, 0, 5'h08, 5'h08);
    exp_push(45, 25'h1008005, 5'h06, 5'h0E, 5'h10, 5'h10, 5'h1A, 5'h00);

    // Clear with a concurrent rejected load (VC1 low>high, D0 high>DEPTH)
    bus.Do_high = 5'd17;
    step(0, 1, 1, 5'h00, 5'h00);
    exp_push(46, 25'h1008005, 5'h06, 5'h0E, 5'h10, 5'h10, 5'h00, 5'h0C);

    // Reset restores default thresholds (low = 1)
    step(1, 0, 0, 5'h00, 5'h00);
    exp_push(50, 25'd0, 5'h1F, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h00);
    step(0, 0, 0, 5'h01, 5'h00);
    step(0, 0, 0, 5'h01, 5'h00);
    exp_push(51, 25'd2, 5'h1E, 5'h1E, 5'h00, 5'h00, 5'h00, 5'h00);

    repeat (3) @(posedge clk);
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_watermark_monitor.md
Name: fifo_watermark_monitor

Overview:
Responder side of the flow-control FSM's threshold interface. It accepts the per-FIFO low/high watermarks from the FSM (latched on init), tracks occupancy of the five datapath FIFOs (main, VC0, VC1, D0, D1) from push/pop strobes, and returns empties[4:0] and sticky errors[4:0] to the FSM, plus almost_empty/almost_full/pause for the datapath. Bit index for all 5-bit vectors: 0=main, 1=VC0, 2=VC1, 3=D0, 4=D1.

Parameters:
DEPTH, 16, FIFO capacity in entries; must be ≤31 so occupancy fits 5 bits
CNT_W, 5, width of occupancy counters and threshold fields

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
init  in  1  threshold load strobe
main_fifo_low, main_fifo_high  in  5 each  main FIFO watermarks
Vco_low, Vco_high  in  5 each  VC0 watermarks
Vc1_low, Vc1_high  in  5 each  VC1 watermarks
Do_low, Do_high  in  5 each  D0 watermarks
D1_low, D1_high  in  5 each  D1 watermarks
push  in  5  per-FIFO write strobe
pop  in  5  per-FIFO read strobe
err_clr  in  1  clears errors and cfg_err
occ  out  25  packed occupancy, FIFO i at [5i+4:5i]
empties  out  5  occupancy == 0
almost_empty  out  5  occ ≤ low threshold
almost_full  out  5  occ ≥ high threshold
pause  out  5  flow-control back-pressure
errors  out  5  sticky overflow/underflow
cfg_err  out  5  sticky rejected-threshold flag

Behaviour:
- Reset (synchronous, priority over everything): occ=0; empties=5'h1F; almost_empty=5'h1F; almost_full=0; pause=0; errors=0; cfg_err=0; internal low thresholds=1, high thresholds=DEPTH-1.
- Threshold load: on a cycle with init=1, each FIFO i with low_i < high_i and high_i ≤ DEPTH gets its thresholds registered. Otherwise that FIFO keeps its old pair and cfg_err[i] is set. Loading never changes occ.
- Occupancy per FIFO, evaluated every cycle:
  - push & ~pop, occ<DEPTH: occ+1.
  - push & ~pop, occ==DEPTH: occ holds; errors[i] set (overflow).
  - pop & ~push, occ>0: occ-1.
  - pop & ~push, occ==0: occ holds; errors[i] set (underflow).
  - push & pop, occ>0: occ holds; no error.
  - push & pop, occ==0: occ becomes 1; errors[i] set (pop underflow).
- Flags are registered and computed from next-state occ and the current thresholds. They update in the same edge as occ, so flags are 1 cycle after the push/pop strobe. Thresholds loaded at edge N affect flags from edge N+1.
- err_clr clears errors and cfg_err. A new error event in the same cycle wins and the bit stays set.
- No wrap-around: counters saturate at 0 and DEPTH.

Optional Feature:
WM_HYSTERESIS_EN
- Defined: pause[i] sets when next occ ≥ high_i and clears only when next occ ≤ low_i. Between the watermarks it holds its value.
- Undefined: pause == almost_full (no hysteresis).

Test Plan:
- Reset then idle 2 cycles -> occ=0, empties=1F, almost_empty=1F, almost_full=0, errors=0.
- init=1 with main 3/6, VC1 A/7 (low>high), others valid; then 6 pushes to main -> main thresholds take effect, cfg_err=5'b00100, almost_empty[0] drops after the 4th push, almost_full[0] rises on the cycle after the 6th push.
- DEPTH+1 pushes to D1 -> occ[24:20]=16, errors[4]=1; err_clr alone -> errors=0. err_clr together with a further push -> errors[4] stays 1.
- Pop on empty VC0 -> errors[1]=1, occ stays 0. Push+pop on empty D0 -> occ[19:15]=1, errors[3]=1.
- Push+pop together on main at occ=5 for 4 cycles -> occ stays 5, no error, flags unchanged.
- With WM_HYSTERESIS_EN, main 3/6: fill to 6 -> pause[0]=1; pop to 4 -> pause[0] stays 1; pop to 3 -> pause[0]=0. Without the macro, pause[0] falls when occ reaches 5.
